// File: rtl/axis_qmac.sv
// -----------------------------------------------------------------------------
// axis_qmac
// Pipelined signed Q16.16 multiply-accumulate: OUT = A*B + C.
// Accepts one operand triple per cycle. There is no backpressure. Each result
// appears exactly LATENCY cycles after its triple is accepted, and results
// leave in the order the triples arrived.
//
// Parameters
//   LATENCY    cycles from operand acceptance to OUT_TVALID (>= 4)
//   FRAC_BITS  fractional bits of the Q format (data width is fixed at 32)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   A/B/C_TDATA, _TVALID     operand streams; accepted only when all three valid
//   OUT_TDATA, OUT_TVALID    result and one-cycle strobe; data holds between strobes
//   IN_FLIGHT                accepted operations not yet presented on OUT
//   ERR                      sticky: a partial set of valids was seen
//
// Optional build macro QMAC_SAT_FLAG_EN
//   OUT_TUSER                per-result saturation flag, aligned with OUT_TVALID
//   SAT_SEEN                 sticky: some result saturated since reset
// -----------------------------------------------------------------------------
module axis_qmac #(
    parameter int LATENCY   = 8,
    parameter int FRAC_BITS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  A_TDATA,
    input  logic                         A_TVALID,
    input  logic [31:0]                  B_TDATA,
    input  logic                         B_TVALID,
    input  logic [31:0]                  C_TDATA,
    input  logic                         C_TVALID,
    output logic [31:0]                  OUT_TDATA,
    output logic                         OUT_TVALID,
    output logic [$clog2(LATENCY+1)-1:0] IN_FLIGHT,
    output logic                         ERR
`ifdef QMAC_SAT_FLAG_EN
    ,
    output logic                         OUT_TUSER,
    output logic                         SAT_SEEN
`endif
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int SUM_W = 64 - FRAC_BITS + 1;
    // S4 plus the pure delay stages. The last entry is the output register.
    localparam int NDLY = (LATENCY >= 4) ? LATENCY - 3 : 1;
    localparam logic [63:0] RND_K = 64'd1 << (FRAC_BITS - 1);

    if (LATENCY < 4) begin : g_latency_check
        $error("axis_qmac: LATENCY must be at least 4");
    end

    logic              accept;
    logic              partial;

    logic              s1_v_q, s1_v_d;
    logic [31:0]       s1_a_q, s1_a_d;
    logic [31:0]       s1_b_q, s1_b_d;
    logic [31:0]       s1_c_q, s1_c_d;

    logic              s2_v_q, s2_v_d;
    logic [63:0]       s2_prod_q, s2_prod_d;
    logic [31:0]       s2_c_q, s2_c_d;

    logic              s3_v_q, s3_v_d;
    logic [SUM_W-1:0]  s3_sum_q, s3_sum_d;

    logic [SUM_W-32:0] sum_upper;
    logic              in_range;
    logic              sat_hi;
    logic              sat_lo;
    logic [31:0]       s4_val;

    logic              stg_in_v [NDLY];
    logic [31:0]       stg_in_d [NDLY];
    logic              dly_v_q  [NDLY];
    logic              dly_v_d  [NDLY];
    logic [31:0]       dly_d_q  [NDLY];
    logic [31:0]       dly_d_d  [NDLY];

    logic [CNT_W-1:0]  in_flight_q, in_flight_d;
    logic              err_q, err_d;

`ifdef QMAC_SAT_FLAG_EN
    logic              stg_in_u [NDLY];
    logic              dly_u_q  [NDLY];
    logic              dly_u_d  [NDLY];
    logic              sat_seen_q, sat_seen_d;
`endif

    always_comb begin
        accept  = A_TVALID & B_TVALID & C_TVALID;
        partial = (A_TVALID | B_TVALID | C_TVALID) & ~accept;

        // S1: register operands
        s1_v_d = accept;
        s1_a_d = A_TDATA;
        s1_b_d = B_TDATA;
        s1_c_d = C_TDATA;

        // S2: full 64-bit signed product
        s2_v_d    = s1_v_q;
        s2_prod_d = 64'($signed(s1_a_q)) * 64'($signed(s1_b_q));
        s2_c_d    = s1_c_q;

        // S3: round half toward +inf, drop the fraction, then add C.
        // The arithmetic shift fills the top bit with the product sign,
        // so the truncated result is the correctly sign-extended sum term.
        s3_v_d   = s2_v_q;
        s3_sum_d = SUM_W'($signed(s2_prod_q + RND_K) >>> FRAC_BITS)
                 + {{(SUM_W - 32){s2_c_q[31]}}, s2_c_q};

        // S4 saturation: the value fits in 32 bits only when every bit above
        // bit 30 matches the sign bit.
        sum_upper = s3_sum_q[SUM_W-1:31];
        in_range  = (&sum_upper) | ~(|sum_upper);
        sat_hi    = ~in_range & ~s3_sum_q[SUM_W-1];
        sat_lo    = ~in_range &  s3_sum_q[SUM_W-1];
        s4_val    = sat_hi ? 32'h7FFF_FFFF :
                    sat_lo ? 32'h8000_0000 : s3_sum_q[31:0];

        // S4 and the delay line. Each stage loads data only with a valid,
        // so the final stage holds the last result between strobes.
        stg_in_v[0] = s3_v_q;
        stg_in_d[0] = s4_val;
        for (int k = 1; k < NDLY; k++) begin
            stg_in_v[k] = dly_v_q[k-1];
            stg_in_d[k] = dly_d_q[k-1];
        end
        for (int k = 0; k < NDLY; k++) begin
            dly_v_d[k] = stg_in_v[k];
            dly_d_d[k] = stg_in_v[k] ? stg_in_d[k] : dly_d_q[k];
        end

`ifdef QMAC_SAT_FLAG_EN
        stg_in_u[0] = sat_hi | sat_lo;
        for (int k = 1; k < NDLY; k++) begin
            stg_in_u[k] = dly_u_q[k-1];
        end
        for (int k = 0; k < NDLY; k++) begin
            dly_u_d[k] = stg_in_v[k] ? stg_in_u[k] : dly_u_q[k];
        end
        sat_seen_d = sat_seen_q | (stg_in_v[NDLY-1] & stg_in_u[NDLY-1]);
`endif

        // The count drops on the edge that loads a result into the output
        // register, so it reads zero while the last strobe is high.
        in_flight_d = in_flight_q;
        case ({accept, stg_in_v[NDLY-1]})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase

        err_d = err_q | partial;

        if (rst) begin
            s1_v_d      = 1'b0;
            s1_a_d      = '0;
            s1_b_d      = '0;
            s1_c_d      = '0;
            s2_v_d      = 1'b0;
            s2_prod_d   = '0;
            s2_c_d      = '0;
            s3_v_d      = 1'b0;
            s3_sum_d    = '0;
            for (int k = 0; k < NDLY; k++) begin
                dly_v_d[k] = 1'b0;
                dly_d_d[k] = '0;
            end
            in_flight_d = '0;
            err_d       = 1'b0;
`ifdef QMAC_SAT_FLAG_EN
            for (int k = 0; k < NDLY; k++) begin
                dly_u_d[k] = 1'b0;
            end
            sat_seen_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        s1_v_q      <= s1_v_d;
        s1_a_q      <= s1_a_d;
        s1_b_q      <= s1_b_d;
        s1_c_q      <= s1_c_d;
        s2_v_q      <= s2_v_d;
        s2_prod_q   <= s2_prod_d;
        s2_c_q      <= s2_c_d;
        s3_v_q      <= s3_v_d;
        s3_sum_q    <= s3_sum_d;
        dly_v_q     <= dly_v_d;
        dly_d_q     <= dly_d_d;
        in_flight_q <= in_flight_d;
        err_q       <= err_d;
`ifdef QMAC_SAT_FLAG_EN
        dly_u_q     <= dly_u_d;
        sat_seen_q  <= sat_seen_d;
`endif
    end

    assign OUT_TDATA  = dly_d_q[NDLY-1];
    assign OUT_TVALID = dly_v_q[NDLY-1];
    assign IN_FLIGHT  = in_flight_q;
    assign ERR        = err_q;
`ifdef QMAC_SAT_FLAG_EN
    assign OUT_TUSER  = dly_u_q[NDLY-1];
    assign SAT_SEEN   = sat_seen_q;
`endif

endmodule

// File: doc/axis_qmac.md
Name: axis_qmac

Overview:
Pipelined fixed-point multiply-accumulate responder that computes OUT = A*B + C. It serves initiators that present A/B/C operand triples and expect results on a fixed-latency, in-order OUT stream, such as the matrix-vector dot engine. Operands and results are signed Q16.16. There is no backpressure: one operation is accepted per cycle and each result appears exactly LATENCY cycles later.

Parameters:
LATENCY, 8, total cycles from operand acceptance to OUT_TVALID; must be >= 4, otherwise $error at elaboration.
FRAC_BITS, 16, number of fractional bits in the Q format; operand and result width is fixed at 32.

Ports:
clk  input  1  clock
rst  input  1  reset
A_TDATA  input  32  multiplicand, signed Q16.16
A_TVALID  input  1  A valid
B_TDATA  input  32  multiplier, signed Q16.16
B_TVALID  input  1  B valid
C_TDATA  input  32  addend, signed Q16.16
C_TVALID  input  1  C valid
OUT_TDATA  output  32  result, signed Q16.16
OUT_TVALID  output  1  one-cycle result strobe
IN_FLIGHT  output  $clog2(LATENCY+1)  number of accepted operations not yet output
ERR  output  1  sticky protocol error

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: OUT_TDATA=0, OUT_TVALID=0, IN_FLIGHT=0, ERR=0. All pipeline valid bits are cleared.
- Reset mid-operation: every in-flight operation is discarded. No OUT_TVALID pulse follows for operations accepted before reset.
- Accept: at a rising edge where A_TVALID && B_TVALID && C_TVALID. There is no ready signal; every triple is accepted.
- Partial valid: any nonzero, non-all-ones subset of the three valids at an edge means:
  - the operands are dropped;
  - ERR is set to 1 and stays set until rst.
- Latency: for an operation accepted at edge n, OUT_TVALID=1 for exactly the cycle between edges n+LATENCY-1 and n+LATENCY.
- Throughput: 1 operation per cycle, results in order. Back-to-back accepts produce back-to-back OUT_TVALID pulses.
- OUT_TDATA: holds the last result while OUT_TVALID=0.
- Pipeline stages:
  - S1 registers the operands and valid.
  - S2 forms the 64-bit signed product A*B.
  - S3 rounds and adds: r = (P + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half toward +inf), then s = r + sign-extended C, carried at 49 bits.
  - S4 saturates s to [0x80000000, 0x7FFFFFFF].
  - LATENCY-4 pure delay stages (data plus valid) follow S4.
  - The output register is the final stage.
- IN_FLIGHT:
  - increments on accept;
  - decrements in the cycle OUT_TVALID is emitted;
  - is unchanged when both happen on the same edge;
  - never exceeds LATENCY.
- Weight, bias and no other state are retained between operations. The block has no FSM beyond the valid-tracking pipeline and counters.

Optional Feature:
Macro QMAC_SAT_FLAG_EN.
- Defined:
  - Adds output port OUT_TUSER (1 bit), aligned with OUT_TVALID, set when that result was saturated.
  - Adds sticky output SAT_SEEN, cleared by rst.
- Undefined: neither port exists. Saturation still occurs, but no flag logic is synthesized.

Test Plan:
1. Basic: A=0x00010000, B=0x00020000, C=0x00008000 accepted at edge 0 -> OUT_TVALID high for exactly one cycle after edge 7, OUT_TDATA=0x00028000; IN_FLIGHT 1 then 0.
2. Signed: A=0xFFFF0000, B=0x00030000, C=0x00010000 -> OUT_TDATA=0xFFFE0000.
3. Rounding:
   - A=0x00000001, B=0x00008000, C=0 -> 0x00000001.
   - A=0x00000001, B=0x00007FFF, C=0 -> 0x00000000.
4. Saturation:
   - A=B=0x7FFF0000, C=0 -> 0x7FFFFFFF.
   - A=0x80000000, B=0x7FFF0000, C=0 -> 0x80000000.
   - With QMAC_SAT_FLAG_EN: OUT_TUSER=1 on both and SAT_SEEN=1.
5. Streaming and reset:
   - Triples with A = 1.0, 2.0, 3.0, 4.0 (0x00010000..0x00040000), B=0x00010000, C=0, on consecutive edges 0-3 -> four consecutive OUT pulses after edges 7-10 with 0x00010000..0x00040000 in order; IN_FLIGHT peaks at 4.
   - Repeat, asserting rst when 3 operations are in flight -> no OUT_TVALID for the following 10 cycles and IN_FLIGHT=0.
6. Protocol error: A_TVALID=B_TVALID=1, C_TVALID=0 -> no OUT_TVALID within 10 cycles and ERR=1. A following valid triple still completes normally; ERR stays 1 until rst.
